// File: rtl/cas_tape_player.sv
// Replays a CAS image from the buffer RAM as an EG2000 cassette pulse train.
// Each byte is sent MSB first as bit cells: a clock pulse, then a data pulse when the bit is 1.
module cas_tape_player #(
  parameter int ADDR_W    = 16,
  parameter int PULSE_LEN = 4200,
  parameter int HALF_CELL = 17500
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              load,
  input  logic              play,
  input  logic [ADDR_W:0]   cas_len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              tape_out,
  output logic              busy,
  output logic              done
);

  localparam int CELL_LEN = 2 * HALF_CELL;
  localparam int CNT_W    = $clog2(CELL_LEN);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELL_LEN - 1);
  localparam logic [CNT_W-1:0] CLK_END  = CNT_W'(PULSE_LEN);
  localparam logic [CNT_W-1:0] DATA_BEG = CNT_W'(HALF_CELL);
  localparam logic [CNT_W-1:0] DATA_END = CNT_W'(HALF_CELL + PULSE_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]  PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, CELL, DONE} state_t;

  state_t           state_reg;
  logic [ADDR_W:0]  ptr_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       next_reg;
  logic [2:0]       bit_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             fill_reg;

  logic [ADDR_W:0]  ptr_inc;
  logic             has_next;
  logic             cur_bit;
  logic             pulse;

  // The pointer compare is one bit wider than the address so a full 2^ADDR_W image ends cleanly.
  assign ptr_inc  = ptr_reg + PTR_ONE;
  assign has_next = (ptr_inc < cas_len);
  assign cur_bit  = shift_reg[bit_reg];
  assign pulse    = (cnt_reg < CLK_END) ||
                    (cur_bit && (cnt_reg >= DATA_BEG) && (cnt_reg < DATA_END));

  always_ff @(posedge clk_sys) begin
    if (reset || load) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      shift_reg <= '0;
      next_reg  <= '0;
      bit_reg   <= '0;
      cnt_reg   <= '0;
      fill_reg  <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      tape_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      // Prefetched byte lands one cycle after the strobe, independent of pause.
      fill_reg <= rd_en && (state_reg == CELL);
      if (fill_reg) begin
        next_reg <= rd_data;
      end

      case (state_reg)
        IDLE: begin
          tape_out <= 1'b0;
          if (play && (cas_len != '0)) begin
            state_reg <= FETCH;
            rd_en     <= 1'b1;
            rd_addr   <= '0;
            busy      <= 1'b1;
          end
        end

        FETCH: begin
          tape_out <= 1'b0;
          if (play) begin
            state_reg <= LATCH;
          end
        end

        LATCH: begin
          tape_out <= 1'b0;
          if (play) begin
            shift_reg <= rd_data;
            bit_reg   <= 3'd7;
            cnt_reg   <= '0;
            state_reg <= CELL;
          end
        end

        CELL: begin
          if (!play) begin
            tape_out <= 1'b0;
          end else begin
            tape_out <= pulse;
            if ((cnt_reg == '0) && (bit_reg == 3'd0) && has_next) begin
              rd_en   <= 1'b1;
              rd_addr <= ptr_inc[ADDR_W-1:0];
            end
            if (cnt_reg == CNT_LAST) begin
              cnt_reg <= '0;
              if (bit_reg != 3'd0) begin
                bit_reg <= bit_reg - 3'd1;
              end else if (has_next) begin
                shift_reg <= next_reg;
                ptr_reg   <= ptr_inc;
                bit_reg   <= 3'd7;
              end else begin
                state_reg <= DONE;
                tape_out  <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
        end

        DONE: begin
          tape_out <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          tape_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cas_tape_player.sv
// Directed bench for cas_tape_player with a short cell (PULSE_LEN=2, HALF_CELL=5).
// A small RAM model feeds the player; a cycle-level golden waveform checks tape_out.
module tb_cas_tape_player;

  localparam int ADDR_W = 16;
  localparam int PL     = 2;
  localparam int HC     = 5;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              load;
  logic              play;
  logic [ADDR_W:0]   cas_len;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              tape_out;
  logic              busy;
  logic              done;

  logic [7:0] mem [0:15];

  int checks = 0;
  int passed = 0;

  cas_tape_player #(
    .ADDR_W   (ADDR_W),
    .PULSE_LEN(PL),
    .HALF_CELL(HC)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .load    (load),
    .play    (play),
    .cas_len (cas_len),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .tape_out(tape_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk_sys = ~clk_sys;

  // Buffer RAM with one-cycle read latency.
  always @(posedge clk_sys) begin
    if (rd_en) rd_data <= mem[rd_addr[3:0]];
  end

  // Expected tape level for stream cycle k (80 cycles per byte, 10 per bit cell).
  function automatic logic golden(input int k);
    int b;
    int bi;
    int c;
    logic [7:0] v;
    b  = k / 80;
    bi = 7 - (k % 80) / 10;
    c  = k % 10;
    v  = mem[b[3:0]];
    return (c < PL) || (v[bi] && (c >= HC) && (c < HC + PL));
  endfunction

  task automatic pulse_load();
    @(negedge clk_sys);
    load = 1'b1;
    @(negedge clk_sys);
    load = 1'b0;
  endtask

  // Plays from IDLE and gathers observations; i counts clock edges on which play was 1.
  task automatic run_play(input int nbytes, input int pause_i, input int pause_len,
                          input int stop_i,
                          output int pulses, output int wave_err, output int rd_hits,
                          output int rd_err, output int stat_err, output int pause_high);
    int i;
    int k;
    int paused;
    int last;
    logic act;
    logic prev;
    logic exp_tape;
    logic exp_rd;
    logic [ADDR_W-1:0] exp_addr;
    i = -1; paused = 0; last = 2 + 80 * nbytes; prev = 1'b0;
    pulses = 0; wave_err = 0; rd_hits = 0; rd_err = 0; stat_err = 0; pause_high = 0;
    while (i < last + 5) begin
      play = !((i + 1 == pause_i) && (paused < pause_len));
      @(negedge clk_sys);
      act = play;
      if (act) i++;
      else paused++;
      k = i - 3;
      exp_tape = 1'b0;
      if (act && (i >= 3) && (i <= last)) exp_tape = golden(k);
      exp_rd = 1'b0;
      exp_addr = '0;
      if (act && (i == 0)) begin
        exp_rd = 1'b1;
      end else if (act && (i >= 3) && (i < last) && (k % 10 == 0) && ((k / 10) % 8 == 7) &&
                   (k / 80 + 1 < nbytes)) begin
        exp_rd = 1'b1;
        exp_addr = ADDR_W'(k / 80 + 1);
      end
      if (tape_out !== exp_tape) wave_err++;
      if ((tape_out === 1'b1) && !prev) pulses++;
      prev = (tape_out === 1'b1);
      if (!act && (tape_out !== 1'b0)) pause_high++;
      if (rd_en === 1'b1) rd_hits++;
      if ((rd_en !== exp_rd) || (exp_rd && (rd_addr !== exp_addr))) rd_err++;
      if ((busy !== ((i >= 0) && (i < last))) || (done !== (i >= last))) stat_err++;
      if (i == stop_i) break;
    end
    play = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; play = 1'b0; cas_len = '0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({tape_out, rd_en, busy, done} !== 4'b0000)
      $display("FAIL reset_flags: got tape/rd_en/busy/done=%b expected 0000",
               {tape_out, rd_en, busy, done});
    else passed++;
    checks++;
    if (rd_addr !== '0) $display("FAIL reset_addr: got %0h expected 0", rd_addr);
    else passed++;
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    checks++;
    if ({tape_out, rd_en, busy, done} !== 4'b0000)
      $display("FAIL idle_flags: got %b expected 0000", {tape_out, rd_en, busy, done});
    else passed++;
  endtask

  task automatic test_empty();
    int n_rd;
    int n_tape;
    int n_busy;
    n_rd = 0; n_tape = 0; n_busy = 0;
    cas_len = '0;
    play = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_sys);
      if (rd_en !== 1'b0) n_rd++;
      if (tape_out !== 1'b0) n_tape++;
      if (busy !== 1'b0) n_busy++;
    end
    play = 1'b0;
    checks++;
    if (n_rd != 0) $display("FAIL empty_rd_en: got %0d cycles expected 0", n_rd);
    else passed++;
    checks++;
    if (n_tape != 0) $display("FAIL empty_tape: got %0d cycles high expected 0", n_tape);
    else passed++;
    checks++;
    if (n_busy != 0) $display("FAIL empty_busy: got %0d cycles busy expected 0", n_busy);
    else passed++;
  endtask

  task automatic test_single_byte();
    int pulses, wave_err, rd_hits, rd_err, stat_err, pause_high;
    mem[0] = 8'hA0;
    cas_len = 17'd1;
    pulse_load();
    run_play(1, -5, 0, -5, pulses, wave_err, rd_hits, rd_err, stat_err, pause_high);
    checks++;
    if (wave_err != 0) $display("FAIL single_wave: got %0d bad cycles expected 0", wave_err);
    else passed++;
    checks++;
    if (pulses != 10) $display("FAIL single_pulses: got %0d expected 10", pulses);
    else passed++;
    checks++;
    if (rd_hits != 1) $display("FAIL single_rd_count: got %0d expected 1", rd_hits);
    else passed++;
    checks++;
    if (rd_err != 0) $display("FAIL single_rd_timing: got %0d bad cycles expected 0", rd_err);
    else passed++;
    checks++;
    if (stat_err != 0) $display("FAIL single_busy_done: got %0d bad cycles expected 0", stat_err);
    else passed++;
    checks++;
    if ({done, busy} !== 2'b10) $display("FAIL single_end: got done/busy=%b expected 10", {done, busy});
    else passed++;
  endtask

  task automatic test_two_bytes();
    int pulses, wave_err, rd_hits, rd_err, stat_err, pause_high;
    mem[0] = 8'hFF;
    mem[1] = 8'h00;
    cas_len = 17'd2;
    pulse_load();
    run_play(2, -5, 0, -5, pulses, wave_err, rd_hits, rd_err, stat_err, pause_high);
    checks++;
    if (wave_err != 0) $display("FAIL two_wave: got %0d bad cycles expected 0", wave_err);
    else passed++;
    checks++;
    if (pulses != 24) $display("FAIL two_pulses: got %0d expected 24", pulses);
    else passed++;
    checks++;
    if (rd_hits != 2) $display("FAIL two_rd_count: got %0d expected 2", rd_hits);
    else passed++;
    checks++;
    if (rd_err != 0) $display("FAIL two_prefetch: got %0d bad cycles expected 0", rd_err);
    else passed++;
    checks++;
    if (stat_err != 0) $display("FAIL two_busy_done: got %0d bad cycles expected 0", stat_err);
    else passed++;
  endtask

  task automatic test_pause();
    int pulses, wave_err, rd_hits, rd_err, stat_err, pause_high;
    pulse_load();
    // Edge index 46 processes c=3 of cell 4.
    run_play(2, 46, 50, -5, pulses, wave_err, rd_hits, rd_err, stat_err, pause_high);
    checks++;
    if (pause_high != 0) $display("FAIL pause_tape: got %0d high cycles expected 0", pause_high);
    else passed++;
    checks++;
    if (wave_err != 0) $display("FAIL pause_resume_wave: got %0d bad cycles expected 0", wave_err);
    else passed++;
    checks++;
    if (pulses != 24) $display("FAIL pause_pulses: got %0d expected 24", pulses);
    else passed++;
    checks++;
    if ((rd_err != 0) || (stat_err != 0))
      $display("FAIL pause_ctrl: got rd_err=%0d stat_err=%0d expected 0/0", rd_err, stat_err);
    else passed++;
  endtask

  task automatic test_reset_load_mid();
    int pulses, wave_err, rd_hits, rd_err, stat_err, pause_high;
    mem[0] = 8'h5A; mem[1] = 8'hC3; mem[2] = 8'h81; mem[3] = 8'h7E; mem[4] = 8'h01;
    cas_len = 17'd5;
    pulse_load();
    // Stop at the first cycle of cell 20 (byte 2), where tape_out is high.
    run_play(5, -5, 0, 203, pulses, wave_err, rd_hits, rd_err, stat_err, pause_high);
    checks++;
    if ((tape_out !== 1'b1) || (busy !== 1'b1))
      $display("FAIL mid_before_reset: got tape/busy=%b expected 11", {tape_out, busy});
    else passed++;
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    checks++;
    if ({tape_out, rd_en, busy, done} !== 4'b0000 || rd_addr !== '0)
      $display("FAIL mid_reset_outputs: got %b addr %0h expected 0000 addr 0",
               {tape_out, rd_en, busy, done}, rd_addr);
    else passed++;
    run_play(5, -5, 0, -5, pulses, wave_err, rd_hits, rd_err, stat_err, pause_high);
    checks++;
    if (wave_err != 0) $display("FAIL after_reset_wave: got %0d bad cycles expected 0", wave_err);
    else passed++;
    checks++;
    if ((rd_hits != 5) || (rd_err != 0))
      $display("FAIL after_reset_reads: got hits=%0d err=%0d expected 5/0", rd_hits, rd_err);
    else passed++;

    pulse_load();
    run_play(5, -5, 0, 203, pulses, wave_err, rd_hits, rd_err, stat_err, pause_high);
    load = 1'b1;
    @(negedge clk_sys);
    load = 1'b0;
    checks++;
    if ({tape_out, rd_en, busy, done} !== 4'b0000 || rd_addr !== '0)
      $display("FAIL mid_load_outputs: got %b addr %0h expected 0000 addr 0",
               {tape_out, rd_en, busy, done}, rd_addr);
    else passed++;
    run_play(5, -5, 0, -5, pulses, wave_err, rd_hits, rd_err, stat_err, pause_high);
    checks++;
    if (wave_err != 0) $display("FAIL after_load_wave: got %0d bad cycles expected 0", wave_err);
    else passed++;
    checks++;
    if (stat_err != 0) $display("FAIL after_load_status: got %0d bad cycles expected 0", stat_err);
    else passed++;
  endtask

  task automatic test_reload();
    int pulses, wave_err, rd_hits, rd_err, stat_err, pause_high;
    int n_rd;
    n_rd = 0;
    play = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_sys);
      if (rd_en !== 1'b0) n_rd++;
    end
    play = 1'b0;
    checks++;
    if ((done !== 1'b1) || (n_rd != 0))
      $display("FAIL done_hold: got done=%b reads=%0d expected 1/0", done, n_rd);
    else passed++;
    load = 1'b1;
    @(negedge clk_sys);
    load = 1'b0;
    checks++;
    if ({done, busy} !== 2'b00) $display("FAIL reload_clear: got done/busy=%b expected 00", {done, busy});
    else passed++;
    run_play(5, -5, 0, -5, pulses, wave_err, rd_hits, rd_err, stat_err, pause_high);
    checks++;
    if (wave_err != 0) $display("FAIL replay_wave: got %0d bad cycles expected 0", wave_err);
    else passed++;
    checks++;
    if ((rd_hits != 5) || (rd_err != 0))
      $display("FAIL replay_reads: got hits=%0d err=%0d expected 5/0", rd_hits, rd_err);
    else passed++;
  endtask

  initial begin
    rd_data = 8'h00;
    for (int a = 0; a < 16; a++) mem[a] = 8'h00;
    test_reset();
    test_empty();
    test_single_byte();
    test_two_bytes();
    test_pause();
    test_reset_load_mid();
    test_reload();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
